// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - two-bit-counter branch predictor with redirect/flush control
//
// Purpose: predicts conditional branches in decode from a table of 2-bit
// saturating counters, trains the table on execute-stage resolution, and
// produces the fetch redirect and pipeline flush controls. Mispredict and
// resolved-branch statistics are kept in saturating 16-bit counters.
//
// Ports:
//   clk, reset        - clock; synchronous active-low reset
//   d_valid, d_is_branch, d_pc, d_target
//                     - decode-stage instruction, its PC and computed target
//   e_valid, e_is_branch, e_pred_taken, e_taken, e_pc, e_target
//                     - execute-stage branch, carried prediction and outcome
//   pred_taken        - decode prediction, piped down with the instruction
//   redirect, redirect_pc
//                     - load fetch PC from redirect_pc this cycle
//   flush_if, flush_id
//                     - squash IF/ID and ID/EX registers
//   stat_branches, stat_mispred
//                     - resolved-branch and misprediction counts
module branch_predict_ctrl #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic        d_is_branch,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_target,
    input  logic        e_valid,
    input  logic        e_is_branch,
    input  logic        e_pred_taken,
    input  logic        e_taken,
    input  logic [31:0] e_pc,
    input  logic [31:0] e_target,
    output logic        pred_taken,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       bht_q [ENTRIES];
    logic [1:0]       bht_d [ENTRIES];
    logic [15:0]      stat_branches_q, stat_branches_d;
    logic [15:0]      stat_mispred_q, stat_mispred_d;

    logic [IDX_W-1:0] d_idx;
    logic [IDX_W-1:0] e_idx;
    logic             d_pred;
    logic             e_br;
    logic             mispredict;
    logic [31:0]      e_fallthrough;
    logic             unused_pc_bits;

    // Word-aligned PCs: the two lowest bits never select an entry.
    assign d_idx          = d_pc[IDX_W+1:2];
    assign e_idx          = e_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{d_pc[31:IDX_W+2], d_pc[1:0]};

    // Decode reads the registered table, so a same-cycle execute update to the
    // same entry is not visible until the next cycle.
    assign d_pred        = d_valid & d_is_branch & bht_q[d_idx][1];
    assign e_br          = e_valid & e_is_branch;
    assign mispredict    = e_br & (e_taken != e_pred_taken);
    assign e_fallthrough = e_pc + 32'd4;

    always_comb begin : redirect_logic
        pred_taken  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        if (reset) begin
            pred_taken = d_pred;
            // The older (execute) instruction owns the redirect; a decode
            // prediction in the same cycle is on the wrong path anyway.
            if (mispredict) begin
                redirect    = 1'b1;
                redirect_pc = e_taken ? e_target : e_fallthrough;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
            end else if (d_pred) begin
                redirect    = 1'b1;
                redirect_pc = d_target;
                flush_if    = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        bht_d           = bht_q;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (e_br) begin
            if (e_taken) begin
                if (bht_q[e_idx] != 2'b11) bht_d[e_idx] = bht_q[e_idx] + 2'd1;
            end else begin
                if (bht_q[e_idx] != 2'b00) bht_d[e_idx] = bht_q[e_idx] - 2'd1;
            end
            if (stat_branches_q != 16'hFFFF) stat_branches_d = stat_branches_q + 16'd1;
            if (mispredict && (stat_mispred_q != 16'hFFFF)) stat_mispred_d = stat_mispred_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
            stat_branches_q <= 16'd0;
            stat_mispred_q  <= 16'd0;
        end else begin
            bht_q           <= bht_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning BHT index width (2^IDX_W entries).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-low (0 = reset).
REQ-004 SHALL have port d_valid  in  1  decode-stage instruction valid.
REQ-005 SHALL have port d_is_branch  in  1  decode instruction is a conditional branch.
REQ-006 SHALL have port d_pc  in  32  decode instruction PC.
REQ-007 SHALL have port d_target  in  32  decode-computed branch target.
REQ-008 SHALL have port e_valid  in  1  execute-stage instruction valid.
REQ-009 SHALL have port e_is_branch  in  1  execute instruction is a conditional branch.
REQ-010 SHALL have port e_pred_taken  in  1  prediction carried down the pipe with this branch.
REQ-011 SHALL have port e_taken  in  1  resolved outcome from the branching unit.
REQ-012 SHALL have port e_pc  in  32  execute instruction PC.
REQ-013 SHALL have port e_target  in  32  execute-computed branch target.
REQ-014 SHALL have port pred_taken  out  1  decode prediction, to be piped with the instruction.
REQ-015 SHALL have port redirect  out  1  PC must be loaded from redirect_pc this cycle.
REQ-016 SHALL have port redirect_pc  out  32  new fetch PC.
REQ-017 SHALL have port flush_if  out  1  squash IF/ID register.
REQ-018 SHALL have port flush_id  out  1  squash ID/EX register.
REQ-019 SHALL have port stat_branches  out  16  resolved-branch count.
REQ-020 SHALL have port stat_mispred  out  16  misprediction count.

Function
REQ-021 SHALL hold a BHT of 2^IDX_W two-bit saturating counters indexed by pc[IDX_W+1:2]; counter value >= 2'b10 means predict taken.
REQ-022 SHALL compute pred_taken combinationally = d_valid & d_is_branch & BHT[d_pc idx][1]; pred_taken SHALL be 0 otherwise.
REQ-023 SHALL define e_br = e_valid & e_is_branch and mispredict = e_br & (e_taken != e_pred_taken), both combinational.
REQ-024 On mispredict SHALL assert redirect, flush_if and flush_id in the same cycle, with redirect_pc = e_target if e_taken else e_pc + 4 (32-bit wrap, carry discarded).
REQ-025 Without mispredict, when pred_taken = 1 SHALL assert redirect and flush_if only (flush_id = 0), with redirect_pc = d_target.
REQ-026 When mispredict and pred_taken are both 1 in the same cycle, the execute redirect SHALL win and the decode redirect SHALL be dropped.
REQ-027 SHALL drive redirect_pc = 0 when redirect = 0.
REQ-028 On each e_br cycle SHALL update BHT[e_pc idx] at the clock edge: increment if e_taken, else decrement, saturating at 2'b11 and 2'b00.
REQ-029 If decode reads the same index that execute updates in the same cycle, the prediction SHALL use the pre-update counter value (no bypass).
REQ-030 SHALL increment stat_branches on each e_br cycle and stat_mispred on each mispredict cycle, both saturating at 16'hFFFF.
REQ-031 SHALL ignore all d_* inputs when d_valid = 0 and all e_* inputs when e_valid = 0; no counter or BHT change SHALL occur.

Reset
REQ-032 When reset = 0 at a rising edge, SHALL set every BHT entry to 2'b01 (weakly not taken) and clear stat_branches and stat_mispred to 0.
REQ-033 While reset = 0, SHALL force redirect, flush_if, flush_id and pred_taken to 0 and redirect_pc to 0, regardless of inputs.
REQ-034 Reset asserted in the same cycle as a mispredict SHALL take priority: no BHT update, no count and no redirect.

Verification
REQ-035 Bench SHALL show: after reset, decode branch at d_pc=0x10 -> pred_taken=0; execute e_pc=0x10, e_taken=1, e_pred_taken=0, e_target=0x40 -> redirect=1, redirect_pc=0x40, flush_if=flush_id=1, stat_mispred=1.
REQ-036 Bench SHALL show: two taken resolutions at e_pc=0x10 -> the next decode of d_pc=0x10 with d_target=0x80 gives pred_taken=1, redirect=1, redirect_pc=0x80, flush_if=1, flush_id=0.
REQ-037 Bench SHALL show: mispredict not-taken at e_pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap).
REQ-038 Bench SHALL show: same-cycle mispredict (e_target=0x200) and decode predict-taken (d_target=0x300) -> redirect_pc=0x200, flush_id=1.
REQ-039 Bench SHALL show: five not-taken updates on one index -> counter saturates at 2'b00; four taken updates -> 2'b11 and pred_taken=1.
REQ-040 Bench SHALL show: preload stat_branches to 0xFFFF via 65535 resolutions, one more -> stays 0xFFFF; reset=0 for one edge -> both stats 0 and all predictions not-taken.
